// File: rtl/risc_ctrl_seq.sv
// risc_ctrl_seq: phase-driven control sequencer producing datapath strobes, stall/halt control and sequence checking.
// Optional EXECUTE memory-wait timeout is enabled by defining CTRL_TIMEOUT_EN.
module risc_ctrl_seq #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TO_W           = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] PHASE,
    input  logic [2:0] OPCODE,
    input  logic       ZERO,
    input  logic       MEM_RDY,
    output logic       PH_ENA_N,
    output logic       IR_LD,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       AC_LD,
    output logic       PC_INC,
    output logic       PC_LD,
    output logic       HALT,
    output logic       SEQ_ERR,
    output logic       MEM_TO
);
    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, UPDATE} phase_t;
    typedef enum logic [2:0] {OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP} op_t;
    typedef enum logic {RUN, HALTED} state_t;

    if (2**TO_W <= TIMEOUT_CYCLES) begin : g_bad_to_w
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

    phase_t     ph;
    op_t        op_q;
    state_t     state;
    logic       zero_q, skip_q, memop, acop, jmp, stall, run, seq_ok;
    logic [1:0] prev_q;

    assign ph     = phase_t'(PHASE);
    assign state  = (HALT | MEM_TO) ? HALTED : RUN;
    assign run    = RST & (state == RUN);
    assign memop  = op_q inside {OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO};
    assign acop   = op_q inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    assign jmp    = op_q == OP_JMP & !skip_q;
    assign stall  = ph == EXECUTE & memop & !skip_q & !MEM_RDY;
    assign seq_ok = (PHASE == prev_q) | (PHASE == 2'(prev_q + 2'd1));

    always_comb begin
        PH_ENA_N = 1'b1;
        IR_LD    = 1'b0;
        MEM_RD   = 1'b0;
        MEM_WR   = 1'b0;
        AC_LD    = 1'b0;
        PC_INC   = 1'b0;
        PC_LD    = 1'b0;
        if (RST && state == RUN) begin
            PH_ENA_N = stall;
            IR_LD    = ph == FETCH;
            MEM_RD   = ph == FETCH | (ph == EXECUTE & memop & op_q != OP_STO & !skip_q);
            MEM_WR   = ph == EXECUTE & op_q == OP_STO & !skip_q;
            AC_LD    = ph == UPDATE & acop & !skip_q;
            PC_LD    = ph == UPDATE & jmp;
            PC_INC   = ph == UPDATE & !jmp;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            op_q    <= OP_HLT;
            zero_q  <= 1'b0;
            skip_q  <= 1'b0;
            prev_q  <= FETCH;
            HALT    <= 1'b0;
            SEQ_ERR <= 1'b0;
        end else begin
            prev_q <= PHASE;
            if (ph == DECODE) begin
                op_q   <= op_t'(OPCODE);
                zero_q <= ZERO;
            end
            // the generator leaves UPDATE only while running, so skip is re-armed there
            if (run && ph == UPDATE)
                skip_q <= op_q == OP_SKZ & zero_q & !skip_q;
            if (run && ph == EXECUTE && op_q == OP_HLT && !skip_q)
                HALT <= 1'b1;
            if (run && !seq_ok)
                SEQ_ERR <= 1'b1;
        end
    end

`ifdef CTRL_TIMEOUT_EN
    logic [TO_W-1:0] wcnt;
    logic            to_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wcnt <= '0;
            to_q <= 1'b0;
        end else if (run && stall) begin
            if (wcnt == TO_W'(TIMEOUT_CYCLES - 1))
                to_q <= 1'b1;
            else
                wcnt <= wcnt + 1'b1;
        end else begin
            wcnt <= '0;
        end
    end

    assign MEM_TO = to_q;
`else
    assign MEM_TO = 1'b0;
`endif
endmodule

// File: tb/tb_risc_ctrl_seq.sv
// tb_risc_ctrl_seq: scoreboard bench; expected output vectors are queued per driven cycle and checked mid-cycle.
module tb_risc_ctrl_seq;
    logic       CLK = 1'b0, RST = 1'b0, ZERO = 1'b0, MEM_RDY = 1'b0;
    logic [1:0] PHASE = 2'd0;
    logic [2:0] OPCODE = 3'd0;
    logic       PH_ENA_N, IR_LD, MEM_RD, MEM_WR, AC_LD, PC_INC, PC_LD, HALT, SEQ_ERR, MEM_TO;
    logic [9:0] obs;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0;

    // vector layout: PE_IR RD WR AC INC LD_HALT SEQ TO
    localparam logic [9:0] IDLE  = 10'b1_000000_000, FET   = 10'b0_110000_000, NONE  = 10'b0_000000_000,
                           RD_OK = 10'b0_010000_000, RD_ST = 10'b1_010000_000, UPD_A = 10'b0_000110_000,
                           WR_ST = 10'b1_001000_000, WR_OK = 10'b0_001000_000, INC   = 10'b0_000010_000,
                           JMPU  = 10'b0_000001_000, HLTD  = 10'b1_000000_100, FET_E = 10'b0_110000_010,
                           UPD_E = 10'b0_000110_010, RST_E = 10'b1_000000_010, TOD   = 10'b1_000000_001;
    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    assign obs = {PH_ENA_N, IR_LD, MEM_RD, MEM_WR, AC_LD, PC_INC, PC_LD, HALT, SEQ_ERR, MEM_TO};

    risc_ctrl_seq #(.TIMEOUT_CYCLES(4), .TO_W(3)) dut (
        .CLK(CLK), .RST(RST), .PHASE(PHASE), .OPCODE(OPCODE), .ZERO(ZERO), .MEM_RDY(MEM_RDY),
        .PH_ENA_N(PH_ENA_N), .IR_LD(IR_LD), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .AC_LD(AC_LD),
        .PC_INC(PC_INC), .PC_LD(PC_LD), .HALT(HALT), .SEQ_ERR(SEQ_ERR), .MEM_TO(MEM_TO)
    );

    always #5 CLK = ~CLK;

    task chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task cyc(input string tag, input logic rst, input logic [1:0] ph, input logic [2:0] op,
             input logic z, input logic rdy, input logic [9:0] e);
        exp_t x;
        RST = rst; PHASE = ph; OPCODE = op; ZERO = z; MEM_RDY = rdy;
        sb.push_back('{tag, e});
        @(negedge CLK);
        x = sb.pop_front();
        chk(x.tag, obs, x.v);
        @(posedge CLK);
        #1;
    endtask

    task instr(input string tag, input logic [2:0] op, input logic z, input logic [9:0] ex, input logic [9:0] up);
        cyc({tag, "_f"}, 1, 0, op, z, 1, FET);
        cyc({tag, "_d"}, 1, 1, op, z, 1, NONE);
        cyc({tag, "_e"}, 1, 2, op, z, 1, ex);
        cyc({tag, "_u"}, 1, 3, op, z, 1, up);
    endtask

    initial begin
        @(posedge CLK);
        #1;
        cyc("rst0", 0, 0, ADD, 0, 1, IDLE);
        cyc("rst1", 0, 2, ADD, 0, 0, IDLE);
        instr("add", ADD, 0, RD_OK, UPD_A);
        cyc("sto_f", 1, 0, STO, 0, 0, FET);
        cyc("sto_d", 1, 1, STO, 0, 0, NONE);
        for (int i = 0; i < 3; i++) cyc("sto_stall", 1, 2, STO, 0, 0, WR_ST);
        cyc("sto_rdy", 1, 2, STO, 0, 1, WR_OK);
        cyc("sto_u", 1, 3, STO, 0, 1, INC);
        instr("skz1", SKZ, 1, NONE, INC);
        cyc("ann_f", 1, 0, STO, 0, 0, FET);
        cyc("ann_d", 1, 1, STO, 0, 0, NONE);
        cyc("ann_e", 1, 2, STO, 0, 0, NONE);
        cyc("ann_u", 1, 3, STO, 0, 0, INC);
        instr("post", ADD, 0, RD_OK, UPD_A);
        instr("skz0", SKZ, 0, NONE, INC);
        instr("jmp", JMP, 0, NONE, JMPU);
        cyc("lda_f", 1, 0, LDA, 0, 0, FET);
        cyc("lda_d", 1, 1, LDA, 0, 0, NONE);
        cyc("lda_st", 1, 2, LDA, 0, 0, RD_ST);
        cyc("lda_e", 1, 2, LDA, 0, 1, RD_OK);
        cyc("lda_u", 1, 3, LDA, 0, 1, UPD_A);
        instr("hlt", HLT, 0, NONE, HLTD);
        for (int i = 0; i < 3; i++) cyc("hlt_hold", 1, 3, ADD, 0, 0, HLTD);
        cyc("hlt_rst0", 0, 3, ADD, 0, 0, HLTD);
        cyc("hlt_rst1", 0, 0, ADD, 0, 0, IDLE);
        cyc("seq_f", 1, 0, ADD, 0, 1, FET);
        for (int i = 0; i < 3; i++) cyc("seq_hold", 1, 1, ADD, 0, 1, NONE);
        cyc("seq_e", 1, 2, ADD, 0, 1, RD_OK);
        cyc("seq_u", 1, 3, ADD, 0, 1, UPD_A);
        cyc("seq_f2", 1, 0, ADD, 0, 1, FET);
        cyc("seq_jump", 1, 2, ADD, 0, 1, RD_OK);
        cyc("seq_err", 1, 3, ADD, 0, 1, UPD_E);
        cyc("seq_stick", 1, 0, ADD, 0, 1, FET_E);
        cyc("seq_rst0", 0, 0, ADD, 0, 1, RST_E);
        cyc("seq_rst1", 0, 0, ADD, 0, 1, IDLE);
`ifdef CTRL_TIMEOUT_EN
        cyc("to_f", 1, 0, LDA, 0, 0, FET);
        cyc("to_d", 1, 1, LDA, 0, 0, NONE);
        for (int i = 0; i < 4; i++) cyc("to_stall", 1, 2, LDA, 0, 0, RD_ST);
        cyc("to_hit", 1, 2, LDA, 0, 0, TOD);
        cyc("to_rst0", 0, 2, LDA, 0, 0, TOD);
        cyc("to_rst1", 0, 0, LDA, 0, 0, IDLE);
        cyc("nto_f", 1, 0, LDA, 0, 0, FET);
        cyc("nto_d", 1, 1, LDA, 0, 0, NONE);
        for (int i = 0; i < 3; i++) cyc("nto_stall", 1, 2, LDA, 0, 0, RD_ST);
        cyc("nto_rdy", 1, 2, LDA, 0, 1, RD_OK);
        cyc("nto_u", 1, 3, LDA, 0, 1, UPD_A);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
